// File: rtl/tact_sqrt_seq.sv
// Sequential restoring square root producing t_act = sqrt(t_sq) * 2^FRAC_BITS.
// Define TACT_SQRT_ROUND_EN for round-half-up with one extra guard iteration.
module tact_sqrt_seq #(
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] t_sq,
    output logic [15:0] t_act,
    output logic        t_valid,
    output logic        busy
);

    localparam int ITER = 8 + FRAC_BITS;
`ifdef TACT_SQRT_ROUND_EN
    localparam int NSTEP = ITER + 1;
`else
    localparam int NSTEP = ITER;
`endif
    localparam int RW = 2 * NSTEP;
    localparam int CW = $clog2(NSTEP + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [RW-1:0]    r_rad;
    logic [NSTEP+1:0] r_rem;
    logic [NSTEP-1:0] r_root;
    logic [CW-1:0]    r_cnt;
    logic [15:0]      r_t_act;
    logic             r_t_valid;

    logic [RW-1:0]    w_rad_ld;
    logic [NSTEP+1:0] w_rem_sh;
    logic [NSTEP+1:0] w_trial;
    logic [NSTEP+1:0] w_rem_nxt;
    logic [NSTEP-1:0] w_root_nxt;
    logic [ITER-1:0]  w_res;
    logic             w_ge;
    logic             w_unused;

    // Fractional bits come from appending zero bit-pairs below the radicand
    assign w_rad_ld   = RW'(t_sq) << (2 * (NSTEP - 8));
    assign w_rem_sh   = {r_rem[NSTEP-1:0], r_rad[RW-1 -: 2]};
    assign w_trial    = {r_root, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = {r_root[NSTEP-2:0], w_ge};
    // Remainder top bits only matter for the final comparison width
    assign w_unused   = ^r_rem[NSTEP+1:NSTEP];

`ifdef TACT_SQRT_ROUND_EN
    logic [ITER-1:0] w_hi;
    assign w_hi  = w_root_nxt[NSTEP-1:1];
    assign w_res = (&w_hi) ? w_hi
                           : w_hi + {{(ITER-1){1'b0}}, w_root_nxt[0]};
`else
    assign w_res = w_root_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rad     <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= '0;
            r_t_act   <= 16'h0000;
            r_t_valid <= 1'b0;
        end else begin
            r_t_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rad   <= w_rad_ld;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_cnt   <= CW'(NSTEP - 1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_nxt;
                    r_root <= w_root_nxt;
                    if (r_cnt == '0) begin
                        r_t_act   <= 16'(w_res);
                        r_t_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_CALC);
    assign t_act    = r_t_act;
    assign t_valid  = r_t_valid;

endmodule

// File: tb/tb_tact_sqrt_seq.sv
// Self-checking bench for tact_sqrt_seq against an arithmetic sqrt model.
// Honours TACT_SQRT_ROUND_EN to select the rounding build's expectations.
module tb_tact_sqrt_seq;

    localparam int F    = 8;
    localparam int ITER = 8 + F;
`ifdef TACT_SQRT_ROUND_EN
    localparam int NSTEP = ITER + 1;
`else
    localparam int NSTEP = ITER;
`endif
    localparam int LAT = NSTEP + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] t_sq;
    logic [15:0] t_act;
    logic        t_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    tact_sqrt_seq #(.FRAC_BITS(F)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .t_sq     (t_sq),
        .t_act    (t_act),
        .t_valid  (t_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic longint isqrt(longint x);
        longint lo = 0;
        longint hi = longint'(1) << 20;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            if (mid * mid <= x) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [15:0] ref_tact(logic [15:0] v);
        longint n = longint'(v) << (2 * F);
        longint maxv = (longint'(1) << ITER) - 1;
        longint r;
`ifdef TACT_SQRT_ROUND_EN
        r = (isqrt(n << 2) + 1) >> 1;
        if (r > maxv) r = maxv;
`else
        r = isqrt(n);
        if (r > maxv) r = maxv;
`endif
        return 16'(r);
    endfunction

    task automatic do_txn(input logic [15:0] v, output logic [15:0] got,
                          output int lat, output logic stable,
                          output logic rdy);
        logic [15:0] prev;
        @(negedge clk);
        in_valid = 1'b1;
        t_sq     = v;
        prev     = t_act;
        @(negedge clk);
        in_valid = 1'b0;
        t_sq     = 16'($urandom);
        lat      = -1;
        got      = 16'hxxxx;
        stable   = 1'b1;
        for (int n = 1; n <= LAT + 5; n++) begin
            if (n > 1) @(negedge clk);
            if (t_valid === 1'b1) begin
                lat = n;
                got = t_act;
                break;
            end
            if (t_act !== prev) stable = 1'b0;
        end
        @(negedge clk);
        rdy = in_ready;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        t_sq     = 16'h1234;
        repeat (3) @(negedge clk);
        checks++;
        if (t_act !== 16'h0000) begin
            errors++;
            $display("FAIL reset_t_act got=%h exp=0000", t_act);
        end
        checks++;
        if (t_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_t_valid got=%b exp=0", t_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_directed;
        logic [15:0] vals[5];
        logic [15:0] exps[5];
        logic [15:0] got;
        int          lat;
        logic        stable;
        logic        rdy;
        vals = '{16'd4, 16'd0, 16'd10, 16'hFFFF, 16'd2};
`ifdef TACT_SQRT_ROUND_EN
        exps = '{16'h0200, 16'h0000, 16'h032A, 16'hFFFF, 16'h016A};
`else
        exps = '{16'h0200, 16'h0000, 16'h0329, 16'hFFFF, 16'h016A};
`endif
        for (int i = 0; i < 5; i++) begin
            do_txn(vals[i], got, lat, stable, rdy);
            checks++;
            if (got !== exps[i]) begin
                errors++;
                $display("FAIL directed_t_act t_sq=%h got=%h exp=%h",
                         vals[i], got, exps[i]);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_latency t_sq=%h got=%0d exp=%0d",
                         vals[i], lat, LAT);
            end
            checks++;
            if (stable !== 1'b1) begin
                errors++;
                $display("FAIL directed_hold t_sq=%h got=changed exp=held",
                         vals[i]);
            end
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed_ready t_sq=%h got=%b exp=1",
                         vals[i], rdy);
            end
        end
    endtask

    task automatic test_ignore_busy;
        int          pulses = 0;
        int          plat = -1;
        logic [15:0] got = 16'h0;
        logic [15:0] g2;
        int          lat;
        logic        stable;
        logic        rdy;
        @(negedge clk);
        in_valid = 1'b1;
        t_sq     = 16'd4;
        for (int n = 1; n <= LAT + 6; n++) begin
            @(negedge clk);
            in_valid = (n == 3 || n == 10);
            t_sq     = 16'd9;
            if (t_valid === 1'b1) begin
                pulses++;
                plat = n;
                got  = t_act;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (got !== 16'h0200) begin
            errors++;
            $display("FAIL ignore_t_act got=%h exp=0200", got);
        end
        checks++;
        if (plat != LAT) begin
            errors++;
            $display("FAIL ignore_latency got=%0d exp=%0d", plat, LAT);
        end
        do_txn(16'd9, g2, lat, stable, rdy);
        checks++;
        if (g2 !== 16'h0300) begin
            errors++;
            $display("FAIL ignore_next_t_act got=%h exp=0300", g2);
        end
    endtask

    task automatic test_reset_mid;
        int          pulses = 0;
        logic [15:0] got;
        int          lat;
        logic        stable;
        logic        rdy;
        @(negedge clk);
        in_valid = 1'b1;
        t_sq     = 16'd100;
        for (int n = 1; n <= LAT + 6; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (n == 8) rst_n = 1'b0;
            if (n == 9) rst_n = 1'b1;
            if (t_valid === 1'b1) pulses++;
            if (n == 10) begin
                checks++;
                if (t_act !== 16'h0000) begin
                    errors++;
                    $display("FAIL midreset_t_act got=%h exp=0000", t_act);
                end
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL midreset_ready got=%b exp=1", in_ready);
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_pulses got=%0d exp=0", pulses);
        end
        do_txn(16'd100, got, lat, stable, rdy);
        checks++;
        if (got !== 16'h0A00) begin
            errors++;
            $display("FAIL midreset_next_t_act got=%h exp=0A00", got);
        end
    endtask

    task automatic test_random;
        logic [15:0] v;
        logic [15:0] got;
        logic [15:0] exp;
        int          lat;
        logic        stable;
        logic        rdy;
        for (int i = 0; i < 20; i++) begin
            v   = 16'($urandom);
            exp = ref_tact(v);
            do_txn(v, got, lat, stable, rdy);
            checks++;
            if (got !== exp || lat != LAT) begin
                errors++;
                $display("FAIL random t_sq=%h got=%h/%0d exp=%h/%0d",
                         v, got, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q[$];
        int          acc[$];
        logic [15:0] v;
        logic [15:0] exp;
        int          sent = 0;
        int          recv = 0;
        for (int c = 0; c < 6 * (LAT + 1) + 20 && recv < 5; c++) begin
            @(negedge clk);
            if (t_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got=%h exp=none", t_act);
                end else begin
                    exp = q.pop_front();
                    if (t_act !== exp) begin
                        errors++;
                        $display("FAIL b2b_t_act got=%h exp=%h", t_act, exp);
                    end
                end
                recv++;
            end
            if (in_ready === 1'b1 && sent < 5) begin
                v        = 16'($urandom);
                in_valid = 1'b1;
                t_sq     = v;
                q.push_back(ref_tact(v));
                acc.push_back(c);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (recv != 5) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=5", recv);
        end
        for (int i = 0; i + 1 < acc.size(); i++) begin
            checks++;
            if (acc[i+1] - acc[i] != NSTEP + 2) begin
                errors++;
                $display("FAIL b2b_period got=%0d exp=%0d",
                         acc[i+1] - acc[i], NSTEP + 2);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        t_sq     = 16'h0000;
        test_reset;
        test_directed;
        test_ignore_busy;
        test_reset_mid;
        test_random;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
